// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTRUCTION_SIZE = 32;
  localparam logic [INSTRUCTION_SIZE-1:0] NOP_ENCODING = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic [INSTRUCTION_SIZE-1:0] align_word(input logic [INSTRUCTION_SIZE-1:0] a);
    return {a[INSTRUCTION_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus: fetch unit (master) drives the address, memory (slave) returns the word.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic [INSTRUCTION_SIZE-1:0] InstructionAddress;
  logic [INSTRUCTION_SIZE-1:0] ReadInstruction;

  modport master (output InstructionAddress, input ReadInstruction);
  modport slave  (input InstructionAddress, output ReadInstruction);
endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register with hold (stall) and load-bubble (flush) controls; bubble wins over hold.
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [INSTRUCTION_SIZE-1:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hold_i,
  input  logic                        bubble_i,
  input  logic [INSTRUCTION_SIZE-1:0] instr_i,
  input  logic [INSTRUCTION_SIZE-1:0] pc_i,
  input  logic [INSTRUCTION_SIZE-1:0] pc_plus4_i,
  output logic [INSTRUCTION_SIZE-1:0] instr_o,
  output logic [INSTRUCTION_SIZE-1:0] pc_o,
  output logic [INSTRUCTION_SIZE-1:0] pc_plus4_o,
  output logic                        valid_o
);

  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic [INSTRUCTION_SIZE-1:0] pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] pc_plus4_q, pc_plus4_d;
  logic                        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d    = NOP_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!hold_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC register, BOOT/RUN/HALT control and IF/ID capture.
// Optional FETCH_PERF_CNT_EN adds FetchCount/StallCount performance counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [INSTRUCTION_SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [INSTRUCTION_SIZE-1:0] NOP_INSTR    = NOP_ENCODING
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Stall,
  input  logic                        Redirect,
  input  logic [INSTRUCTION_SIZE-1:0] RedirectTarget,
  input  logic                        Halt,
  instruction_fetch_unit_if.master    imem,
  output logic [INSTRUCTION_SIZE-1:0] IfId_Instruction,
  output logic [INSTRUCTION_SIZE-1:0] IfId_PC,
  output logic [INSTRUCTION_SIZE-1:0] IfId_PCPlus4,
  output logic                        IfId_Valid,
  output logic                        FetchMisaligned,
  output logic                        Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                 FetchCount,
  output logic [31:0]                 StallCount
`endif
);

  fetch_state_e                state_q, state_d;
  logic [INSTRUCTION_SIZE-1:0] pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] pc_plus4;
  logic                        misaligned_q, misaligned_d;
  logic                        halted_q, halted_d;
  logic                        ifid_hold;
  logic                        ifid_bubble;
  logic                        fetch_load;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    halted_d     = halted_q;
    misaligned_d = 1'b0;
    ifid_hold    = 1'b0;
    ifid_bubble  = 1'b0;
    fetch_load   = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = RUN;
      end
      RUN, HALT: begin
        // Redirect is the only input honoured in HALT, so RUN and HALT share its handling.
        if (Redirect) begin
          pc_d         = align_word(RedirectTarget);
          ifid_bubble  = 1'b1;
          misaligned_d = |RedirectTarget[1:0];
          state_d      = RUN;
          halted_d     = 1'b0;
        end else if (state_q == HALT) begin
          ifid_bubble = 1'b1;
        end else if (Halt) begin
          ifid_bubble = 1'b1;
          state_d     = HALT;
          halted_d    = 1'b1;
        end else if (Stall) begin
          ifid_hold = 1'b1;
        end else begin
          pc_d       = pc_plus4;
          fetch_load = 1'b1;
        end
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      halted_q     <= halted_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (ifid_hold || !fetch_load && !ifid_bubble),
    .bubble_i   (ifid_bubble),
    .instr_i    (imem.ReadInstruction),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_o    (IfId_Instruction),
    .pc_o       (IfId_PC),
    .pc_plus4_o (IfId_PCPlus4),
    .valid_o    (IfId_Valid)
  );

  assign imem.InstructionAddress = pc_q;
  assign FetchMisaligned         = misaligned_q;
  assign Halted                  = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_load};
    stall_cnt_d = stall_cnt_q + {31'd0, ifid_hold};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule
